sprite_render: RTL

SPRITE_RENDER -- requirements
Module: sprite_render

---
 rtl/sprite_render.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sprite_render.sv
// sprite_render: overlays a SPRITE_W x SPRITE_H sprite, fetched from an
// external synchronous ROM, onto a background colour stream. The sprite
// position and 1x/2x scale are double-buffered: writes land in pending
// registers and only become active on frame_tick, so a frame never tears.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   video_on              - current pixel is in the visible area
//   pixel_x, pixel_y      - current pixel coordinate
//   frame_tick            - one pulse per frame, during blanking
//   pos_wr                - strobe capturing pos_x_in/pos_y_in/scale2x_in
//   bg_rgb                - background colour for the current pixel
//   rom_row, rom_col      - ROM address (combinational from pixel inputs)
//   color_data            - ROM data, one cycle after the address
//   rgb, video_on_out     - final colour and aligned video_on (2-cycle latency)
//   sprite_hit            - opaque sprite pixel, aligned with rgb
module sprite_render #(
  parameter int          SPRITE_W    = 10,
  parameter int          SPRITE_H    = 20,
  parameter logic [11:0] TRANSPARENT = 12'h000,
  parameter logic [9:0]  INIT_X      = 10'd100,
  parameter logic [9:0]  INIT_Y      = 10'd50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        frame_tick,
  input  logic        pos_wr,
  input  logic [9:0]  pos_x_in,
  input  logic [9:0]  pos_y_in,
  input  logic        scale2x_in,
  input  logic [11:0] bg_rgb,
  output logic [4:0]  rom_row,
  output logic [3:0]  rom_col,
  input  logic [11:0] color_data,
  output logic [11:0] rgb,
  output logic        video_on_out,
  output logic        sprite_hit
);

  logic [9:0]  act_x, act_y, pend_x, pend_y;
  logic        act_s, pend_s, pend;

  logic [10:0] dx, dy, lim_w, lim_h;
  logic        in_box;

  logic        hit_p1, vld_p1;
  logic [11:0] bg_p1;
  logic        opaque;

  function automatic logic [11:0] pick_rgb(input logic        vld,
                                           input logic        hit,
                                           input logic [11:0] color,
                                           input logic [11:0] bg);
    if (!vld)     return 12'h000;
    else if (hit) return color;
    else          return bg;
  endfunction

  // Position/scale registers. On a simultaneous write and frame_tick the
  // active set takes the old pending value while the new request is parked.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_x  <= INIT_X;
      act_y  <= INIT_Y;
      act_s  <= 1'b0;
      pend_x <= '0;
      pend_y <= '0;
      pend_s <= 1'b0;
      pend   <= 1'b0;
    end else begin
      if (frame_tick && pend) begin
        act_x <= pend_x;
        act_y <= pend_y;
        act_s <= pend_s;
      end
      if (pos_wr) begin
        pend_x <= pos_x_in;
        pend_y <= pos_y_in;
        pend_s <= scale2x_in;
        pend   <= 1'b1;
      end else if (frame_tick) begin
        pend   <= 1'b0;
      end
    end
  end

  // Stage 0: hit test and ROM address. 11-bit arithmetic; the >= terms
  // guarantee dx/dy never wrap when in_box is set.
  always_comb begin
    dx      = {1'b0, pixel_x} - {1'b0, act_x};
    dy      = {1'b0, pixel_y} - {1'b0, act_y};
    lim_w   = act_s ? 11'(SPRITE_W * 2) : 11'(SPRITE_W);
    lim_h   = act_s ? 11'(SPRITE_H * 2) : 11'(SPRITE_H);
    in_box  = (pixel_x >= act_x) && (pixel_y >= act_y) &&
              (dx < lim_w) && (dy < lim_h);
    rom_col = '0;
    rom_row = '0;
    if (in_box) begin
      rom_col = 4'(dx >> act_s);
      rom_row = 5'(dy >> act_s);
    end
  end

  // Stage 1: align hit flag, video_on and background with ROM data.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_p1 <= 1'b0;
      vld_p1 <= 1'b0;
      bg_p1  <= '0;
    end else begin
      hit_p1 <= in_box;
      vld_p1 <= video_on;
      bg_p1  <= bg_rgb;
    end
  end

  assign opaque = hit_p1 && (color_data != TRANSPARENT);

  // Stage 2: colour select and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb          <= '0;
      video_on_out <= 1'b0;
      sprite_hit   <= 1'b0;
    end else begin
      rgb          <= pick_rgb(vld_p1, opaque, color_data, bg_p1);
      video_on_out <= vld_p1;
      sprite_hit   <= vld_p1 && opaque;
    end
  end

endmodule
